// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one start bit, DBIT data bits LSB first,
// optional even parity bit, stop period of SB_tck oversampling ticks.
// Bit timing comes from the shared 16x baud tick s_tck.
// Optional feature macro: UART_TX_PARITY_EN (inserts a PARITY state).
module uart_tx #(
  parameter int DBIT   = 8,
  parameter int SB_tck = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tck,
  input  logic [7:0] din,
  output logic       tx_done_tck,
  output logic       tx_busy,
  output logic       tx
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [7:0] DMASK = 8'((1 << DBIT) - 1);
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [4:0] S_LAST  = 5'd15;
  localparam logic [4:0] SB_LAST = 5'(SB_tck - 1);
  localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

  state_t     state;
  logic [4:0] s;
  logic [2:0] n;
  logic [7:0] b;
  logic       tx_reg;
`ifdef UART_TX_PARITY_EN
  logic       par;
`endif

  // Final stop tick: pulse in the same cycle, state leaves STOP on this edge
  assign tx_done_tck = (state == STOP) && s_tck && (s == SB_LAST);
  assign tx_busy     = (state != IDLE);
  assign tx          = tx_reg;

  // Frame sequencer; tx_reg is loaded with the value of the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      tx_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // a tick coincident with acceptance is deliberately not counted
          if (tx_start) begin
            b      <= din;
            s      <= '0;
            state  <= START;
            tx_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par    <= ^(din & DMASK);
`endif
          end
        end
        START: begin
          if (s_tck) begin
            if (s == S_LAST) begin
              s      <= '0;
              n      <= '0;
              state  <= DATA;
              tx_reg <= b[0];
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tck) begin
            if (s == S_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                state  <= PARITY;
                tx_reg <= par;
`else
                state  <= STOP;
                tx_reg <= 1'b1;
`endif
              end else begin
                n      <= n + 3'd1;
                tx_reg <= b[1];
              end
            end else begin
              s <= s + 5'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tck) begin
            if (s == S_LAST) begin
              s      <= '0;
              state  <= STOP;
              tx_reg <= 1'b1;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tck) begin
            if (s == SB_LAST) begin
              state <= IDLE;
            end else begin
              s <= s + 5'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tx_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: two transmitters (8 data / 1 stop, 7 data / 2 stop) checked
// cycle by cycle against a tick-count frame model, plus a frame table and
// hand-written multi-cycle sequences.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk;
  logic       reset;
  logic       s_tck;
  logic       start0, start1;
  logic [7:0] din0, din1;
  logic       done0, done1, busy0, busy1, tx0, tx1;

  uart_tx #(.DBIT(8), .SB_tck(16)) u0 (
    .clk(clk), .reset(reset), .tx_start(start0), .s_tck(s_tck), .din(din0),
    .tx_done_tck(done0), .tx_busy(busy0), .tx(tx0));

  uart_tx #(.DBIT(7), .SB_tck(32)) u1 (
    .clk(clk), .reset(reset), .tx_start(start1), .s_tck(s_tck), .din(din1),
    .tx_done_tck(done1), .tx_busy(busy1), .tx(tx1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests, fails, cyc_no, tck_per;
  bit rnd_tck;
  logic       nx_reset;
  logic       nx_start [2];
  logic [7:0] nx_din   [2];
  logic       smp_tx [2], smp_busy [2], smp_done [2], smp_tck;

  // frame model: per DUT, active flag, ticks elapsed since acceptance, byte
  bit         m_act [2];
  int         m_t   [2];
  logic [7:0] m_b   [2];

  function automatic int dbit(input int d);
    return (d == 0) ? 8 : 7;
  endfunction

  function automatic int flen(input int d);
    return 16 * (1 + dbit(d) + PB) + ((d == 0) ? 16 : 32);
  endfunction

  function automatic logic m_tx(input int d);
    int idx;
    logic [7:0] msk;
    if (!m_act[d]) return 1'b1;
    idx = m_t[d] / 16;
    msk = 8'((1 << dbit(d)) - 1);
    if (idx == 0) return 1'b0;
    if (idx <= dbit(d)) return m_b[d][idx-1];
    if (PB == 1 && idx == dbit(d) + 1) return ^(m_b[d] & msk);
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // one clock: drive at negedge, compare against model, advance model at posedge
  task automatic cyc();
    @(negedge clk);
    reset  = nx_reset;
    start0 = nx_start[0];
    start1 = nx_start[1];
    din0   = nx_din[0];
    din1   = nx_din[1];
    s_tck  = rnd_tck ? ($urandom_range(tck_per - 1) == 0) : ((cyc_no % tck_per) == 0);
    #1;
    smp_tck     = s_tck;
    smp_tx[0]   = tx0;   smp_tx[1]   = tx1;
    smp_busy[0] = busy0; smp_busy[1] = busy1;
    smp_done[0] = done0; smp_done[1] = done1;
    if (cyc_no >= 2) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d tx c%0d", d, cyc_no), 32'(smp_tx[d]), 32'(m_tx(d)));
        chk($sformatf("d%0d busy c%0d", d, cyc_no), 32'(smp_busy[d]), 32'(m_act[d]));
        chk($sformatf("d%0d done c%0d", d, cyc_no), 32'(smp_done[d]),
            32'(m_act[d] && s_tck && (m_t[d] == flen(d) - 1)));
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) m_act[d] = 1'b0;
      else if (!m_act[d]) begin
        if (d == 0 ? start0 : start1) begin
          m_act[d] = 1'b1;
          m_t[d]   = 0;
          m_b[d]   = (d == 0) ? din0 : din1;
        end
      end else if (s_tck) begin
        if (m_t[d] == flen(d) - 1) m_act[d] = 1'b0;
        else m_t[d]++;
      end
    end
    cyc_no++;
  endtask

  // send one byte; returns ticks to done, mid-bit line samples, done count
  task automatic run_frame(input int d, input logic [7:0] v, input int per, input bit rnd,
                           output int ticks, output logic [11:0] bits, output int ndone);
    int tc;
    bit fin;
    tck_per = per; rnd_tck = rnd;
    ticks = -1; bits = '1; ndone = 0; tc = 0; fin = 0;
    nx_start[d] = 1'b1; nx_din[d] = v;
    cyc();
    nx_start[d] = 1'b0; nx_din[d] = 8'($urandom);
    for (int k = 0; k < 4000 && !fin; k++) begin
      cyc();
      if (tc % 16 == 8 && tc / 16 < 12) bits[tc/16] = smp_tx[d];
      if (smp_done[d]) begin ndone++; ticks = tc + 1; fin = 1; end
      if (smp_tck) tc++;
    end
    cyc();
    chk($sformatf("d%0d busy after done", d), 32'(smp_busy[d]), 32'd0);
  endtask

  typedef struct {
    int         d;
    logic [7:0] v;
    int         per;
    bit         rnd;
    int         ticks;
    logic [11:0] bits;   // bit i = line value of frame bit i (start first)
  } vec_t;

  vec_t tbl [7];

  initial begin
    int ticks, nd, tc, dc, fc;
    logic [11:0] bits, msk;
    bit fin, pulsed;

    tests = 0; fails = 0; cyc_no = 0; tck_per = 4; rnd_tck = 0;
    nx_reset = 1'b1;
    nx_start[0] = 1'b0; nx_start[1] = 1'b0;
    nx_din[0] = 8'h00;  nx_din[1] = 8'h00;
    reset = 1'b1; s_tck = 1'b0; start0 = 1'b0; start1 = 1'b0; din0 = 8'h00; din1 = 8'h00;
    for (int d = 0; d < 2; d++) begin m_act[d] = 1'b0; m_t[d] = 0; m_b[d] = 8'h00; end

    tbl[0] = '{0, 8'hA5, 4, 0, 160 + 16*PB, PB ? 12'b1101_0100_1010 : 12'b1111_0100_1010};
    tbl[1] = '{0, 8'h00, 1, 0, 160 + 16*PB, PB ? 12'b1100_0000_0000 : 12'b1110_0000_0000};
    tbl[2] = '{0, 8'hFF, 2, 0, 160 + 16*PB, PB ? 12'b1101_1111_1110 : 12'b1111_1111_1110};
    tbl[3] = '{0, 8'h01, 3, 1, 160 + 16*PB, 12'b1110_0000_0010};
    tbl[4] = '{1, 8'hC1, 3, 0, 160 + 16*PB, PB ? 12'b1110_1000_0010 : 12'b1111_1000_0010};
    tbl[5] = '{1, 8'h55, 2, 1, 160 + 16*PB, PB ? 12'b1110_1010_1010 : 12'b1111_1010_1010};
    tbl[6] = '{0, 8'h55, 2, 0, 160 + 16*PB, PB ? 12'b1100_1010_1010 : 12'b1110_1010_1010};

    repeat (3) cyc();
    nx_reset = 1'b0;
    cyc();
    chk("reset tx0", 32'(smp_tx[0]), 32'd1);
    chk("reset busy0", 32'(smp_busy[0]), 32'd0);
    chk("reset done1", 32'(smp_done[1]), 32'd0);
    repeat (3) cyc();

    // frame table
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].d, tbl[i].v, tbl[i].per, tbl[i].rnd, ticks, bits, nd);
      msk = 12'((1 << (2 + dbit(tbl[i].d) + PB)) - 1);
      chk($sformatf("tbl%0d frame ticks", i), 32'(ticks), 32'(tbl[i].ticks));
      chk($sformatf("tbl%0d bits", i), 32'(bits & msk), 32'(tbl[i].bits & msk));
      chk($sformatf("tbl%0d done count", i), 32'(nd), 32'd1);
      repeat (2) cyc();
    end

    // back-to-back: start held high, 0x00 then 0xFF
    tck_per = 2; rnd_tck = 0;
    nx_start[0] = 1'b1; nx_din[0] = 8'h00;
    dc = -1; fin = 0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      cyc();
      if (smp_done[0]) begin dc = cyc_no - 1; fin = 1; end
    end
    chk("b2b first done seen", 32'(fin), 32'd1);
    nx_din[0] = 8'hFF;
    cyc();
    chk("b2b gap tx high", 32'(smp_tx[0]), 32'd1);
    chk("b2b gap idle", 32'(smp_busy[0]), 32'd0);
    nx_start[0] = 1'b0;
    cyc();
    fc = cyc_no - 1;
    chk("b2b restart offset", 32'(fc - dc), 32'd2);
    chk("b2b start bit", 32'(smp_tx[0]), 32'd0);
    fin = 0; nd = 0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      cyc();
      if (smp_done[0]) begin nd++; fin = 1; end
    end
    chk("b2b second done", 32'(nd), 32'd1);
    repeat (3) cyc();

    // start pulse during data bit 3 must be ignored
    tck_per = 3;
    nx_start[0] = 1'b1; nx_din[0] = 8'h96;
    cyc();
    nx_start[0] = 1'b0;
    tc = 0; nd = 0; fin = 0; pulsed = 0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      cyc();
      if (!pulsed && tc == 16*4 + 5) begin
        nx_start[0] = 1'b1; nx_din[0] = 8'h3C; pulsed = 1;
      end else nx_start[0] = 1'b0;
      if (smp_done[0]) begin nd++; fin = 1; end
      if (smp_tck) tc++;
    end
    nx_start[0] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (smp_done[0]) nd++;
    end
    chk("ignored start done count", 32'(nd), 32'd1);
    chk("ignored start no extra frame", 32'(smp_busy[0]), 32'd0);

    // reset during DATA abandons the frame
    tck_per = 2;
    nx_start[0] = 1'b1; nx_din[0] = 8'hE7;
    cyc();
    nx_start[0] = 1'b0;
    tc = 0;
    for (int k = 0; k < 4000 && tc < 16*3 + 5; k++) begin
      cyc();
      if (smp_tck) tc++;
    end
    chk("pre-reset busy", 32'(smp_busy[0]), 32'd1);
    nx_reset = 1'b1;
    cyc();
    nx_reset = 1'b0;
    cyc();
    chk("mid reset tx", 32'(smp_tx[0]), 32'd1);
    chk("mid reset busy", 32'(smp_busy[0]), 32'd0);
    chk("mid reset done", 32'(smp_done[0]), 32'd0);
    repeat (2) cyc();
    run_frame(0, 8'h55, 2, 0, ticks, bits, nd);
    msk = 12'((1 << (10 + PB)) - 1);
    chk("post reset 0x55 bits", 32'(bits & msk), 32'(tbl[6].bits & msk));
    chk("post reset 0x55 ticks", 32'(ticks), 32'(160 + 16*PB));

    // random traffic on both transmitters, model checks every cycle
    rnd_tck = 1;
    for (int k = 0; k < 4000; k++) begin
      if (k % 500 == 0) tck_per = 1 + int'($urandom_range(2));
      nx_start[0] = ($urandom_range(15) == 0);
      nx_start[1] = ($urandom_range(15) == 0);
      nx_din[0]   = 8'($urandom);
      nx_din[1]   = 8'($urandom);
      nx_reset    = ($urandom_range(999) == 0);
      cyc();
    end
    nx_reset = 1'b0; nx_start[0] = 1'b0; nx_start[1] = 1'b0;
    repeat (5) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
